// File: rtl/operand_fetch.sv
// ID/EX operand stage: regfile read indexing, EX/WB bypass, load-use hazard
// detection and a single-entry ID/EX latch with valid/ready on both sides.
module operand_fetch #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned ZERO_REG = 31,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rn,
    input  logic [4:0]       in_rm,
    input  logic [4:0]       in_rd,
    input  logic [WIDTH-1:0] in_imm,
    input  logic             in_useImm,
    output logic [4:0]       readReg0,
    output logic [4:0]       readReg1,
    input  logic [WIDTH-1:0] readData0,
    input  logic [WIDTH-1:0] readData1,
    input  logic             exWrEn,
    input  logic [4:0]       exReg,
    input  logic [WIDTH-1:0] exResult,
    input  logic             exResultValid,
    input  logic             wbWrEn,
    input  logic [4:0]       wbReg,
    input  logic [WIDTH-1:0] wbData,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_opA,
    output logic [WIDTH-1:0] out_opB,
    output logic [4:0]       out_rd,
    output logic [CNT_W-1:0] stallCount
);

    localparam int unsigned IDX_W = 5;
    localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(ZERO_REG);

    typedef struct packed {
        logic             hazard;
        logic [WIDTH-1:0] value;
    } src_t;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic [4:0]       r_rd;
    logic [CNT_W-1:0] r_stall_cnt;

    src_t             w_srcA;
    src_t             w_srcB;
    logic [WIDTH-1:0] w_opB;
    logic             w_hazard;
    logic             w_in_ready;
    logic             w_capture;
    logic             w_stall;

    // Bypass priority: zero register, then EX (may be a load still in flight), then WB, then regfile.
    function automatic src_t select_src(
        input logic [4:0]       idx,
        input logic [WIDTH-1:0] rf_data,
        input logic             ex_wr,
        input logic [4:0]       ex_reg,
        input logic [WIDTH-1:0] ex_res,
        input logic             ex_res_vld,
        input logic             wb_wr,
        input logic [4:0]       wb_reg,
        input logic [WIDTH-1:0] wb_dat
    );
        src_t s;
        s.hazard = 1'b0;
        s.value  = rf_data;
        if (idx == ZERO_IDX) begin
            s.value = '0;
        end else if (ex_wr && (ex_reg == idx)) begin
            s.hazard = !ex_res_vld;
            s.value  = ex_res;
        end else if (wb_wr && (wb_reg == idx)) begin
            s.value = wb_dat;
        end
        return s;
    endfunction

    assign readReg0 = in_rn;
    assign readReg1 = in_rm;

    always_comb begin
        w_srcA = select_src(in_rn, readData0, exWrEn, exReg, exResult, exResultValid,
                            wbWrEn, wbReg, wbData);
        w_srcB = select_src(in_rm, readData1, exWrEn, exReg, exResult, exResultValid,
                            wbWrEn, wbReg, wbData);
    end

    assign w_opB      = in_useImm ? in_imm : w_srcB.value;
    assign w_hazard   = in_valid && (w_srcA.hazard || (!in_useImm && w_srcB.hazard));
    assign w_in_ready = !w_hazard && (!r_out_valid || out_ready);
    assign w_capture  = in_valid && w_in_ready && !flush;
    assign w_stall    = in_valid && !w_in_ready && !flush;

    // ID/EX latch: flush beats capture; data holds whenever nothing new is captured.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_opA       <= '0;
            r_opB       <= '0;
            r_rd        <= ZERO_IDX;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_opA       <= w_srcA.value;
            r_opB       <= w_opB;
            r_rd        <= in_rd;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Saturating count of cycles an offered instruction was refused.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_opA    = r_opA;
    assign out_opB    = r_opB;
    assign out_rd     = r_rd;
    assign stallCount = r_stall_cnt;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus random traffic against a
// cycle-level behavioural model of the operand stage.
module tb_operand_fetch;

    localparam int unsigned WIDTH = 64;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid, in_ready, in_useImm;
    logic [4:0]       in_rn, in_rm, in_rd, readReg0, readReg1;
    logic [WIDTH-1:0] in_imm, readData0, readData1;
    logic             exWrEn, exResultValid, wbWrEn, flush;
    logic [4:0]       exReg, wbReg;
    logic [WIDTH-1:0] exResult, wbData;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out_opA, out_opB;
    logic [4:0]       out_rd;
    logic [31:0]      stallCount;

    logic             s_in_ready, s_out_valid;
    logic [4:0]       s_readReg0, s_readReg1, s_out_rd;
    logic [WIDTH-1:0] s_out_opA, s_out_opB;
    logic [2:0]       s_stallCount;

    logic [WIDTH-1:0] rf [32];

    int errors = 0;
    int checks = 0;

    logic             m_valid;
    logic [WIDTH-1:0] m_opA, m_opB;
    logic [4:0]       m_rd;
    longint unsigned  m_cnt;

    always #5 clk = ~clk;

    assign readData0 = (readReg0 == 5'd31) ? '0 : rf[readReg0];
    assign readData1 = (readReg1 == 5'd31) ? '0 : rf[readReg1];

    operand_fetch dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd), .in_imm(in_imm), .in_useImm(in_useImm),
        .readReg0(readReg0), .readReg1(readReg1), .readData0(readData0), .readData1(readData1),
        .exWrEn(exWrEn), .exReg(exReg), .exResult(exResult), .exResultValid(exResultValid),
        .wbWrEn(wbWrEn), .wbReg(wbReg), .wbData(wbData), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_opA(out_opA), .out_opB(out_opB),
        .out_rd(out_rd), .stallCount(stallCount)
    );

    // Narrow-counter instance so saturation is reachable in simulation.
    operand_fetch #(.CNT_W(3)) u_sat (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd), .in_imm(in_imm), .in_useImm(in_useImm),
        .readReg0(s_readReg0), .readReg1(s_readReg1), .readData0(readData0), .readData1(readData1),
        .exWrEn(exWrEn), .exReg(exReg), .exResult(exResult), .exResultValid(exResultValid),
        .wbWrEn(wbWrEn), .wbReg(wbReg), .wbData(wbData), .flush(flush),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_opA(s_out_opA), .out_opB(s_out_opB),
        .out_rd(s_out_rd), .stallCount(s_stallCount)
    );

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Value a source register should read as, given the in-flight writers ({hazard, value}).
    function automatic logic [WIDTH:0] ref_src(input logic [4:0] idx);
        if (idx == 5'd31)                    return '0;
        if (exWrEn && exReg == idx)          return exResultValid ? {1'b0, exResult} : {1'b1, 64'd0};
        if (wbWrEn && wbReg == idx)          return {1'b0, wbData};
        return {1'b0, rf[idx]};
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_opA = '0; m_opB = '0; m_rd = 5'd31; m_cnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
        chk({tag, ".out_opA"}, out_opA, m_opA);
        chk({tag, ".out_opB"}, out_opB, m_opB);
        chk({tag, ".out_rd"}, 64'(out_rd), 64'(m_rd));
        chk({tag, ".stallCount"}, 64'(stallCount), 64'(m_cnt));
        chk({tag, ".stallSat"}, 64'(s_stallCount), (m_cnt > 7) ? 64'd7 : 64'(m_cnt));
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic step(input string tag);
        logic [WIDTH:0] a, b;
        logic           hz, rdy, wr;
        logic [4:0]     wreg;
        logic [WIDTH-1:0] wdat;
        #1;
        a   = ref_src(in_rn);
        b   = in_useImm ? {1'b0, in_imm} : ref_src(in_rm);
        hz  = in_valid && (a[WIDTH] || b[WIDTH]);
        rdy = !hz && (!m_valid || out_ready);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(rdy));
        chk({tag, ".readReg"}, 64'({readReg0, readReg1}), 64'({in_rn, in_rm}));
        wr = wbWrEn; wreg = wbReg; wdat = wbData;
        @(posedge clk);
        if (in_valid && !rdy && !flush && m_cnt != 64'hFFFF_FFFF) m_cnt++;
        if (flush) m_valid = 1'b0;
        else if (in_valid && rdy) begin
            m_valid = 1'b1; m_opA = a[WIDTH-1:0]; m_opB = b[WIDTH-1:0]; m_rd = in_rd;
        end else if (m_valid && out_ready) m_valid = 1'b0;
        if (wr && wreg != 5'd31) rf[wreg] = wdat;
        #1;
        check_outputs(tag);
    endtask

    task automatic idle();
        in_valid = 0; in_rn = 0; in_rm = 0; in_rd = 0; in_imm = '0; in_useImm = 0;
        exWrEn = 0; exReg = 0; exResult = '0; exResultValid = 1;
        wbWrEn = 0; wbReg = 0; wbData = '0; flush = 0; out_ready = 1;
    endtask

    function automatic logic [4:0] rnd_idx();
        return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        longint unsigned base;
        for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
        idle();
        reset_n = 0;
        model_reset();
        #12;
        check_outputs("reset");
        reset_n = 1;
        @(posedge clk); #1;
        check_outputs("post_reset");

        // Async reset mid-operation: entry rd=5 held, 7 stall cycles accumulated.
        rf[1] = 64'h5;
        in_valid = 1; in_rn = 1; in_rm = 2; in_rd = 5; out_ready = 0;
        step("fill");
        in_rd = 6;
        repeat (7) step("bp_stall");
        chk("pre_reset.stallCount", 64'(stallCount), 64'd7);
        chk("pre_reset.out_rd", 64'(out_rd), 64'd5);
        reset_n = 0;
        model_reset();
        #1;
        check_outputs("async_reset");
        chk("async_reset.rd31", 64'(out_rd), 64'd31);
        #1 reset_n = 1;

        // WB bypass beats stale regfile contents.
        idle();
        rf[3] = 64'h30;
        wbWrEn = 1; wbReg = 3; wbData = 64'hABCD; in_valid = 1; in_rn = 3; in_rd = 1;
        step("wb_bypass");
        chk("wb_bypass.opA", out_opA, 64'hABCD);

        // EX beats WB; X31 is never forwarded.
        idle();
        in_valid = 1; in_rm = 4; in_rn = 0;
        exWrEn = 1; exReg = 4; exResult = 64'h11; wbWrEn = 1; wbReg = 4; wbData = 64'h22;
        step("ex_prio");
        chk("ex_prio.opB", out_opB, 64'h11);
        in_rn = 31; exReg = 31; wbReg = 31;
        step("zero_reg");
        chk("zero_reg.opA", out_opA, 64'h0);

        // Load-use stall for 3 cycles, then the load result arrives.
        idle();
        base = m_cnt;
        in_valid = 1; in_rn = 7; in_rm = 0; in_rd = 8;
        exWrEn = 1; exReg = 7; exResultValid = 0;
        repeat (3) begin
            step("load_use");
            chk("load_use.in_ready", 64'(in_ready), 64'd0);
        end
        chk("load_use.count", 64'(stallCount), base + 3);
        exResultValid = 1; exResult = 64'h99;
        step("load_done");
        chk("load_done.opA", out_opA, 64'h99);
        in_rn = 1; in_rm = 7; in_useImm = 1; in_imm = 64'hFFFF_FFFF_FFFF_FFF0; exResultValid = 0;
        step("imm_nohz");
        chk("imm_nohz.opB", out_opB, 64'hFFFF_FFFF_FFFF_FFF0);
        chk("imm_nohz.count", 64'(stallCount), base + 3);

        // Backpressure: held entry stays bit-stable, then released with no bubble.
        idle();
        in_valid = 1; in_rn = 1; in_rd = 2;
        step("bp_fill");
        in_rn = 3; in_rd = 9; out_ready = 0;
        exWrEn = 1; exReg = 1; exResult = 64'hDEAD;
        repeat (4) begin
            step("bp_hold");
            chk("bp_hold.opA", out_opA, 64'h5);
            chk("bp_hold.rd", 64'(out_rd), 64'd2);
        end
        out_ready = 1;
        step("bp_release");
        chk("bp_release.rd", 64'(out_rd), 64'd9);
        chk("bp_release.valid", 64'(out_valid), 64'd1);

        // Flush wins over a capture-eligible instruction.
        idle();
        in_valid = 1; in_rd = 12; flush = 1;
        step("flush");
        chk("flush.valid", 64'(out_valid), 64'd0);
        chk("flush.rd", 64'(out_rd), 64'd9);

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            in_rn         = rnd_idx();
            in_rm         = rnd_idx();
            in_rd         = 5'($urandom_range(0, 31));
            in_imm        = {$urandom, $urandom};
            in_useImm     = ($urandom_range(0, 3) == 0);
            exWrEn        = ($urandom_range(0, 1) == 0);
            exReg         = rnd_idx();
            exResult      = {$urandom, $urandom};
            exResultValid = ($urandom_range(0, 3) != 0);
            wbWrEn        = ($urandom_range(0, 1) == 0);
            wbReg         = rnd_idx();
            wbData        = {$urandom, $urandom};
            flush         = ($urandom_range(0, 15) == 0);
            out_ready     = ($urandom_range(0, 2) != 0);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
